// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [2:0] {
        SCAN,
        DEBOUNCE,
        EMIT,
        HELD,
        RELEASE
    } statetype;

    // Column drive pattern after reset: column 0 driven low.
    localparam logic [3:0] COL_RST = 4'b1110;

    // Key codes indexed [row][col].
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // Index of the lowest-numbered active-low row.
    function automatic logic [1:0] lowest_low(input logic [3:0] rows);
        if (!rows[0]) return 2'd0;
        if (!rows[1]) return 2'd1;
        if (!rows[2]) return 2'd2;
        return 2'd3;
    endfunction

    // Active-low one-hot column drive for a column index.
    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/keypad_scan_fsm_if.sv
// Keypad matrix and key-code output bundle.
interface keypad_scan_fsm_if;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic       new_hex;
    logic [3:0] hex_new;

    modport master (input row_n, output col_n, output new_hex, output hex_new);
    modport slave  (output row_n, input col_n, input new_hex, input hex_new);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with a configurable reset value.
module sync_2ff #(
    parameter int unsigned           WIDTH   = 4,
    parameter logic [WIDTH-1:0]      RST_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/keypad_scan_fsm.sv
// 4x4 keypad scanner: column scan, press/release debounce, one pulse per press.
module keypad_scan_fsm #(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 20000
) (
    input  logic               clk,
    input  logic               reset,
    keypad_scan_fsm_if.master  bus
);
    import keypad_pkg::*;

    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CNT);

    statetype          state_q, state_d;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [1:0]        row_idx_q, row_idx_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [3:0]        col_n_q, col_n_d;
    logic              new_hex_q, new_hex_d;
    logic [3:0]        hex_new_q, hex_new_d;
    logic [3:0]        row_s;
    logic              row_rel;
    logic              scan_end;
    logic              deb_end;

    sync_2ff #(
        .WIDTH   (4),
        .RST_VAL (4'b1111)
    ) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.row_n),
        .q     (row_s)
    );

    assign row_rel  = row_s[row_idx_q];
    assign scan_end = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    assign deb_end  = (deb_cnt_q == DEB_W'(DEBOUNCE_CNT - 1));

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= SCAN;
            col_idx_q  <= 2'd0;
            row_idx_q  <= 2'd0;
            scan_cnt_q <= '0;
            deb_cnt_q  <= '0;
            col_n_q    <= COL_RST;
            new_hex_q  <= 1'b0;
            hex_new_q  <= 4'h0;
        end else begin
            state_q    <= state_d;
            col_idx_q  <= col_idx_d;
            row_idx_q  <= row_idx_d;
            scan_cnt_q <= scan_cnt_d;
            deb_cnt_q  <= deb_cnt_d;
            col_n_q    <= col_n_d;
            new_hex_q  <= new_hex_d;
            hex_new_q  <= hex_new_d;
        end
    end

    // Next-state logic; pulse and code are set on the transition into EMIT.
    always_comb begin
        state_d    = state_q;
        col_idx_d  = col_idx_q;
        row_idx_d  = row_idx_q;
        scan_cnt_d = scan_cnt_q;
        deb_cnt_d  = deb_cnt_q;
        new_hex_d  = 1'b0;
        hex_new_d  = hex_new_q;

        case (state_q)
            SCAN: begin
                scan_cnt_d = scan_cnt_q + SCAN_W'(1);
                if (scan_end) begin
                    scan_cnt_d = '0;
                    if (row_s != 4'hF) begin
                        row_idx_d = lowest_low(row_s);
                        deb_cnt_d = '0;
                        state_d   = DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
            end
            DEBOUNCE: begin
                if (row_rel) begin
                    scan_cnt_d = '0;
                    state_d    = SCAN;
                end else if (deb_end) begin
                    new_hex_d = 1'b1;
                    hex_new_d = KEYMAP[row_idx_q][col_idx_q];
                    state_d   = EMIT;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            EMIT: begin
                state_d = HELD;
            end
            HELD: begin
                if (row_rel) begin
                    deb_cnt_d = '0;
                    state_d   = RELEASE;
                end
            end
            RELEASE: begin
                if (!row_rel) begin
                    state_d = HELD;
                end else if (deb_end) begin
                    scan_cnt_d = '0;
                    col_idx_d  = col_idx_q + 2'd1;
                    state_d    = SCAN;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase

        col_n_d = col_drive(col_idx_d);
    end

    assign bus.col_n   = col_n_q;
    assign bus.new_hex = new_hex_q;
    assign bus.hex_new = hex_new_q;
endmodule
